inst_prefetch_buf: RTL
======================

Name: inst_prefetch_buf

Overview:
- Parametrised instruction prefetch queue placed between instruction memory (or I-cache) and the IF/ID register.
- Generalises single-entry fetch to a Depth-entry FIFO of {pc, inst} pairs.
- Fetches sequentially, decoupling imem stalls from ID stalls.
- Supports pipeline redirect (branch/flush) with safe discard of a stalled in-flight request.

Parameters:
AddrWidth, 32, width of PC and imem address
InstrWidth, 32, instruction width
Depth, 4, queue entries; power of two, >= 2
ResetPc, 32'h0000_0000, first fetch address after reset
NopInstr, 32'h0000_0013, value driven on inst_o when queue empty

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock, asynchronous, active-low
imem_read_o  out  1  fetch request
imem_addr_o  out  AddrWidth  fetch address
imem_inst_i  in  InstrWidth  fetched instruction; valid when imem_read_o=1 and imem_stall_i=0
imem_stall_i  in  1  request not yet complete (stallreq_from_imem)
redirect_i  in  1  flush queue, refetch from redirect_pc_i
redirect_pc_i  in  AddrWidth  new fetch PC
inst_valid_o  out  1  head entry valid
inst_o  out  InstrWidth  head instruction
pc_o  out  AddrWidth  head PC
inst_ready_i  in  1  consumer accepts head this cycle (ID not stalled)
count_o  out  $clog2(Depth)+1  occupancy

Behaviour:
- Reset values:
  - state=IDLE, count=0, rd/wr pointers 0, fetch_pc=ResetPc.
  - Outputs: imem_read_o=0, imem_addr_o=ResetPc, inst_valid_o=0, inst_o=NopInstr, pc_o=0, count_o=0.
  - Reset mid-operation drops all entries and any in-flight request.
- States:
  - IDLE: transitions to FETCH on the first clk edge after rstn deasserts.
  - FETCH: imem_read_o=1 when count<Depth, or while a request is outstanding (imem_stall_i=1).
  - DISCARD: imem_read_o=1 with the old address held until the stalled request completes. The returned data is dropped; the next state is FETCH with fetch_pc=latched redirect PC.
- Address hold: once imem_read_o=1 and imem_stall_i=1, imem_addr_o and imem_read_o stay constant until imem_stall_i=0.
- Completion: on an edge where imem_read_o=1 and imem_stall_i=0 in FETCH:
  - {fetch_pc, imem_inst_i} is written at the tail.
  - fetch_pc += 4 (mod 2^AddrWidth; wraps at all-ones).
- Pop: on an edge with inst_valid_o=1 and inst_ready_i=1, the head advances. inst_o/pc_o always reflect the head combinationally; NopInstr/0 when empty.
- Push and pop in the same edge: count unchanged. Pointers wrap modulo Depth.
- Full (count=Depth):
  - No new request issued.
  - A request already stalled (issued when count<Depth) is impossible, so no overflow can occur.
  - Issue is not gated by same-cycle pop (no ready->read combinational path).
- Empty: inst_valid_o=0; inst_ready_i ignored.
- Redirect (highest priority) at an edge:
  - The queue empties (count=0) and any same-cycle pop or push is ignored.
  - If no request is stalled (imem_stall_i=0 or imem_read_o=0): fetch_pc=redirect_pc_i, state FETCH. The first new request appears the next cycle.
  - If a request is stalled (imem_read_o=1, imem_stall_i=1): latch redirect_pc_i and go to DISCARD.
  - A redirect in DISCARD overwrites the latched PC.
  - A redirect in IDLE only updates fetch_pc.
- Latency: with imem_stall_i=0 throughout, an instruction at PC X is visible on inst_o one cycle after its request cycle. Steady-state throughput is 1 instr/cycle.
- redirect_pc_i[1:0] is used as given (no alignment check).

Test Plan:
1. Reset, imem_stall_i=0, inst_ready_i=0 -> requests at 0x0,0x4,0x8,0xC on consecutive cycles; then imem_read_o=0, count_o=4. Raise ready -> pops in order, pc_o 0x0..0xC, and fetch resumes at 0x10.
2. Streaming with ready=1, no stalls -> inst_valid_o continuously 1 from the second FETCH cycle; pc_o increments by 4 per cycle; count_o stays 1.
3. imem_stall_i=1 for 3 cycles on the request at 0x8 -> imem_addr_o held at 0x8 with read held; entry pc=0x8 pushed on the completion edge; no duplicate or skipped PCs.
4. Redirect to 0x200 with 3 entries queued and no stall -> next cycle count_o=0, inst_valid_o=0, imem_addr_o=0x200; first popped pc_o=0x200.
5. Redirect to 0x300 while the request at 0x14 is stalled 2 more cycles, then a second redirect to 0x400 in DISCARD -> the 0x14 data is never enqueued; the next request is at 0x400.
6. Simultaneous push and pop at count=Depth-1 with pointer wrap, and rstn dropped asynchronously mid-stall -> outputs return to reset values immediately; after release, fetch restarts at ResetPc.

Source files
------------

// File: rtl/inst_prefetch_buf_if.sv
// Fetch-side and consume-side signals of the instruction prefetch queue.
// Signal names carry the direction as seen from the queue itself.
interface inst_prefetch_buf_if #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned InstrWidth = 32,
  parameter int unsigned CntWidth   = 3
);
  // Instruction memory side
  logic                  imem_read_o;
  logic [AddrWidth-1:0]  imem_addr_o;
  logic [InstrWidth-1:0] imem_inst_i;
  logic                  imem_stall_i;

  // Pipeline control side
  logic                  redirect_i;
  logic [AddrWidth-1:0]  redirect_pc_i;

  // Decode side
  logic                  inst_valid_o;
  logic [InstrWidth-1:0] inst_o;
  logic [AddrWidth-1:0]  pc_o;
  logic                  inst_ready_i;
  logic [CntWidth-1:0]   count_o;

  modport master (
    output imem_read_o, imem_addr_o, inst_valid_o, inst_o, pc_o, count_o,
    input  imem_inst_i, imem_stall_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  imem_read_o, imem_addr_o, inst_valid_o, inst_o, pc_o, count_o,
    output imem_inst_i, imem_stall_i, redirect_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/inst_prefetch_buf.sv
// Sequential instruction prefetch FIFO of {pc, inst} pairs between imem and IF/ID,
// with redirect handling that safely drains a stalled in-flight fetch.
module inst_prefetch_buf #(
  parameter int unsigned           AddrWidth  = 32,
  parameter int unsigned           InstrWidth = 32,
  parameter int unsigned           Depth      = 4,
  parameter logic [AddrWidth-1:0]  ResetPc    = '0,
  parameter logic [InstrWidth-1:0] NopInstr   = InstrWidth'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rstn,
  inst_prefetch_buf_if.master bus
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  localparam logic [CntWidth-1:0]  DepthCnt = CntWidth'(Depth);
  localparam logic [AddrWidth-1:0] PcStep   = AddrWidth'(4);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
    $error("inst_prefetch_buf: Depth must be a power of two and >= 2");
  end

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrWidth-1:0] redir_pc_q, redir_pc_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;

  logic [AddrWidth-1:0]  pc_mem_q   [Depth];
  logic [InstrWidth-1:0] inst_mem_q [Depth];

  logic empty, full;
  logic imem_read;
  logic stalled;
  logic push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // A stalled request can never coexist with full: it was issued below Depth and
  // only pops can happen while it waits, so gating on !full keeps it asserted.
  // NOTE: every signal driven in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    imem_read = 1'b0;
    case (state_q)
      StFetch:   imem_read = !full;
      StDiscard: imem_read = 1'b1;
      default:   imem_read = 1'b0;
    endcase
  end

  assign stalled = imem_read && bus.imem_stall_i;
  assign push    = (state_q == StFetch) && imem_read && !bus.imem_stall_i && !bus.redirect_i;
  assign pop     = !empty && bus.inst_ready_i && !bus.redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (bus.redirect_i) fetch_pc_d = bus.redirect_pc_i;
      end
      StFetch: begin
        if (bus.redirect_i) begin
          if (stalled) begin
            // The old address must stay on the bus until imem finishes with it.
            state_d    = StDiscard;
            redir_pc_d = bus.redirect_pc_i;
          end else begin
            fetch_pc_d = bus.redirect_pc_i;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + PcStep;
        end
      end
      StDiscard: begin
        if (stalled) begin
          if (bus.redirect_i) redir_pc_d = bus.redirect_pc_i;
        end else begin
          state_d    = StFetch;
          fetch_pc_d = bus.redirect_i ? bus.redirect_pc_i : redir_pc_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      count_d = count_q + CntWidth'(push) - CntWidth'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPc;
      redir_pc_q <= ResetPc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= bus.imem_inst_i;
    end
  end

  assign bus.imem_read_o  = imem_read;
  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.inst_valid_o = !empty;
  assign bus.inst_o       = empty ? NopInstr : inst_mem_q[rd_ptr_q];
  assign bus.pc_o         = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign bus.count_o      = count_q;

endmodule
